// File: rtl/mips_cpu_avalon_ram.sv
// rtl/mips_cpu_avalon_ram.sv - unified instr/data simulation memory on one Avalon-MM port
// Optional random stalls: define MIPS_MEM_RANDOM_STALL_EN.
module mips_cpu_avalon_ram #(
    parameter logic [31:0] INSTR_BASE      = 32'hBFC00000,
    parameter int          INSTR_DEPTH     = 256,
    parameter logic [31:0] DATA_BASE       = 32'h00001000,
    parameter int          DATA_DEPTH      = 1024,
    parameter string       INSTR_INIT_FILE = "",
    parameter string       DATA_INIT_FILE  = "",
    parameter int          WAIT_CYCLES     = 1,
    parameter int          INSTR_WRITABLE  = 0,
    parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        error
);

    localparam int CW = $clog2(WAIT_CYCLES + 4);
    localparam int IW = $clog2(INSTR_DEPTH);
    localparam int DW = $clog2(DATA_DEPTH);
    localparam logic [31:0] INSTR_END = INSTR_BASE + 32'(4 * INSTR_DEPTH);
    localparam logic [31:0] DATA_END  = DATA_BASE + 32'(4 * DATA_DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [CW-1:0]  target_q, target_next, start_target;
    logic [31:0]    lat_addr, lat_addr_next;
    logic           error_set;
    logic           complete;
    logic           do_write;
    logic           lfsr_step;
    logic [1:0]     extra;

    logic [31:0] imem [INSTR_DEPTH];
    logic [31:0] dmem [DATA_DEPTH];

    initial begin
        for (int i = 0; i < INSTR_DEPTH; i++) imem[i] = '0;
        for (int i = 0; i < DATA_DEPTH; i++) dmem[i] = '0;
    end

`ifdef MIPS_MEM_RANDOM_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11; steps once per accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= STALL_SEED;
        end else if (lfsr_step) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign extra = lfsr[1:0];
`else
    localparam logic [15:0] unused_seed = STALL_SEED;
    logic unused_step;

    assign unused_step = lfsr_step;
    assign extra       = 2'd0;
`endif

    assign start_target = CW'(WAIT_CYCLES) + CW'(extra);

    logic           hit_i, hit_d, fault;
    logic [IW-1:0]  i_idx;
    logic [DW-1:0]  d_idx;

    assign hit_i = (address >= INSTR_BASE) && (address < INSTR_END);
    assign hit_d = (address >= DATA_BASE) && (address < DATA_END);
    assign i_idx = IW'((address - INSTR_BASE) >> 2);
    assign d_idx = DW'((address - DATA_BASE) >> 2);
    assign fault = !(hit_i || hit_d) || (address[1:0] != 2'b00) ||
                   (write && hit_i && (INSTR_WRITABLE == 0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            target_q <= '0;
            lat_addr <= '0;
            error    <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            target_q <= target_next;
            lat_addr <= lat_addr_next;
            if (error_set) error <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        target_next   = target_q;
        lat_addr_next = lat_addr;
        waitrequest   = 1'b0;
        readdata      = '0;
        error_set     = 1'b0;
        complete      = 1'b0;
        do_write      = 1'b0;
        lfsr_step     = 1'b0;

        if (reset) begin
            waitrequest = 1'b1;
        end else if (read && write) begin
            error_set  = 1'b1;
            state_next = S_IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (read || write) begin
                        lfsr_step = 1'b1;
                        if (start_target == '0) begin
                            complete = 1'b1;
                        end else begin
                            waitrequest   = 1'b1;
                            lat_addr_next = address;
                            cnt_next      = CW'(1);
                            target_next   = start_target;
                            state_next    = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!(read || write)) begin
                        state_next = S_IDLE;
                        cnt_next   = '0;
                    end else if (address != lat_addr) begin
                        // a moved address is treated as a fresh start of the same length
                        waitrequest   = 1'b1;
                        lat_addr_next = address;
                        cnt_next      = CW'(1);
                    end else if (cnt < target_q) begin
                        waitrequest = 1'b1;
                        cnt_next    = cnt + CW'(1);
                    end else begin
                        complete   = 1'b1;
                        state_next = S_IDLE;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end

        if (complete) begin
            if (fault) begin
                error_set = 1'b1;
            end else if (read) begin
                readdata = hit_i ? imem[i_idx] : dmem[d_idx];
            end else begin
                do_write = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    if (hit_i) imem[i_idx][8*b +: 8] <= writedata[8*b +: 8];
                    else       dmem[d_idx][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_avalon_ram.sv
// tb/tb_mips_cpu_avalon_ram.sv - directed self-checking bench for mips_cpu_avalon_ram
// Build with MIPS_MEM_RANDOM_STALL_EN defined to exercise the random-stall path.
module tb_mips_cpu_avalon_ram;

`ifdef MIPS_MEM_RANDOM_STALL_EN
    localparam int WC = 1;
`else
    localparam int WC = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_cpu_avalon_ram #(
        .WAIT_CYCLES    (WC),
        .INSTR_WRITABLE (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .error       (error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // called at posedge+1; returns at posedge+1 after the completion edge
    task automatic wait_done(output int lat, output logic [31:0] rd);
        bit done;
        lat  = 0;
        rd   = '0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!waitrequest) begin
                rd   = readdata;
                done = 1'b1;
            end else begin
                lat++;
                if (lat > 40) begin
                    check("timeout", 32'(lat), 32'd0);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic rd_en, input logic wr_en, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output int lat, output logic [31:0] rd);
        read       = rd_en;
        write      = wr_en;
        address    = a;
        writedata  = d;
        byteenable = be;
        wait_done(lat, rd);
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

`ifndef MIPS_MEM_RANDOM_STALL_EN
    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        int lat;
        logic [31:0] rd;
        xfer(1'b1, 1'b0, a, 32'h0, 4'h0, lat, rd);
        check({tag, "_lat"}, 32'(lat), 32'(WC));
        check({tag, "_data"}, rd, exp);
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be);
        int lat;
        logic [31:0] rd;
        xfer(1'b0, 1'b1, a, d, be, lat, rd);
        check({tag, "_lat"}, 32'(lat), 32'(WC));
    endtask

    task automatic do_fault(input string tag, input logic rd_en, input logic wr_en,
                            input logic [31:0] a, input logic [31:0] d);
        int lat;
        logic [31:0] rd;
        xfer(rd_en, wr_en, a, d, 4'hF, lat, rd);
        check({tag, "_lat"}, 32'(lat), 32'(WC));
        check({tag, "_rdata"}, rd, 32'h0);
        @(negedge clk);
        check({tag, "_err"}, 32'(error), 32'd1);
        @(posedge clk);
        #1 apply_reset();
        @(negedge clk);
        check({tag, "_err_clr"}, 32'(error), 32'd0);
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] rd;
        reset      = 1'b1;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        byteenable = '0;
`ifndef MIPS_MEM_RANDOM_STALL_EN
        #2 dut.imem[0] = 32'h3C011234;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wait", 32'(waitrequest), 32'd1);
        check("rst_rdata", readdata, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_err", 32'(error), 32'd0);
        check("idle_wait", 32'(waitrequest), 32'd0);
        check("idle_rdata", readdata, 32'h0);
        @(posedge clk);
        #1;

`ifndef MIPS_MEM_RANDOM_STALL_EN
        do_read("rom", 32'hBFC00000, 32'h3C011234);
        @(negedge clk);
        check("rom_after_rdata", readdata, 32'h0);
        @(posedge clk);
        #1;

        do_write("w1000", 32'h00001000, 32'h55667788, 4'hF);
        do_write("w1004", 32'h00001004, 32'h11223344, 4'hF);
        do_write("w1008", 32'h00001008, 32'hCAFEF00D, 4'hF);
        do_write("wbe", 32'h00001004, 32'hAABBCCDD, 4'b0101);
        do_read("rbe", 32'h00001004, 32'h11BB33DD);
        do_write("wbe0", 32'h00001004, 32'hFFFFFFFF, 4'b0000);
        do_read("rbe0", 32'h00001004, 32'h11BB33DD);
        check("data_err", 32'(error), 32'd0);

        do_fault("rom_wr", 1'b0, 1'b1, 32'hBFC00004, 32'h12345678);
        do_fault("unmapped", 1'b1, 1'b0, 32'h00000000, 32'h0);
        do_fault("misal_wr", 1'b0, 1'b1, 32'h00001002, 32'hFFFFFFFF);
        do_fault("misal_rd", 1'b1, 1'b0, 32'h00001002, 32'h0);
        do_read("rom_kept", 32'hBFC00004, 32'h00000000);
        do_read("misal_kept", 32'h00001000, 32'h55667788);

        read    = 1'b1;
        address = 32'h00001004;
        @(negedge clk);
        check("drop_wait1", 32'(waitrequest), 32'd1);
        @(posedge clk);
        #1 read = 1'b0;
        @(negedge clk);
        check("drop_wait0", 32'(waitrequest), 32'd0);
        check("drop_rdata", readdata, 32'h0);
        @(posedge clk);
        #1;
        do_read("after_drop", 32'h00001008, 32'hCAFEF00D);
        check("drop_err", 32'(error), 32'd0);

        read    = 1'b1;
        address = 32'h00001004;
        @(negedge clk);
        @(posedge clk);
        #1 address = 32'h00001008;
        wait_done(lat, rd);
        read = 1'b0;
        check("addr_chg_lat", 32'(lat), 32'(WC));
        check("addr_chg_data", rd, 32'hCAFEF00D);

        read       = 1'b1;
        write      = 1'b1;
        address    = 32'h00001000;
        writedata  = 32'h0;
        byteenable = 4'hF;
        @(negedge clk);
        check("ill_wait", 32'(waitrequest), 32'd0);
        check("ill_rdata", readdata, 32'h0);
        @(posedge clk);
        #1 read = 1'b0;
        write = 1'b0;
        @(negedge clk);
        check("ill_err", 32'(error), 32'd1);
        @(posedge clk);
        #1 apply_reset();
        do_read("ill_nowrite", 32'h00001000, 32'h55667788);

        write      = 1'b1;
        address    = 32'h00001008;
        writedata  = 32'hDEADDEAD;
        byteenable = 4'hF;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rstmid_wait", 32'(waitrequest), 32'd1);
        check("rstmid_rdata", readdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        write = 1'b0;
        @(negedge clk);
        check("rstmid_err", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        do_read("rstmid_nowrite", 32'h00001008, 32'hCAFEF00D);

        do_read("b2b_a", 32'h00001000, 32'h55667788);
        do_read("b2b_b", 32'h00001004, 32'h11BB33DD);
        check("final_err", 32'(error), 32'd0);
`else
        begin
            logic [15:0] m;
            logic [31:0] pat [8];
            int exp_lat;
            m = 16'hACE1;
            for (int k = 0; k < 8; k++) begin
                pat[k]  = 32'h01020304 * (k + 1) ^ 32'hA5A50000;
                exp_lat = WC + int'(m[1:0]);
                m       = lfsr_next(m);
                xfer(1'b0, 1'b1, 32'h00001000 + 32'(4 * k), pat[k], 4'hF, lat, rd);
                check("rs_wlat", 32'(lat), 32'(exp_lat));
            end
            for (int i = 0; i < 100; i++) begin
                exp_lat = WC + int'(m[1:0]);
                m       = lfsr_next(m);
                xfer(1'b1, 1'b0, 32'h00001000 + 32'(4 * (i % 8)), 32'h0, 4'h0, lat, rd);
                check("rs_range", 32'(lat >= 1 && lat <= 4), 32'd1);
                check("rs_lat", 32'(lat), 32'(exp_lat));
                check("rs_data", rd, pat[i % 8]);
            end
            check("rs_err", 32'(error), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
